// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for an async FIFO, with burst locking.
// A granted requester holds the port until req_last, MAX_BURST beats or a stall timeout.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                          wt_clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          wt_en,
  output logic [DATA_WIDTH-1:0]         wdata,
  input  logic                          full,
  input  logic                          overflow,
  output logic [$clog2(NUM_REQ)-1:0]    owner,
  output logic                          busy,
  output logic                          ovf_err,
  output logic                          tmo_pulse
);

  localparam int OW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t        state;
  logic [OW-1:0] rr_ptr;
  logic [BW-1:0] beat_cnt;
  logic [TW-1:0] stall_cnt;
  logic          gap;
  logic          found;
  logic [OW-1:0] win;

  function automatic logic [OW-1:0] nxt(input logic [OW-1:0] x);
    return (int'(x) == NUM_REQ - 1) ? '0 : x + OW'(1);
  endfunction

  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = OW'(idx);
      end
    end
  end

  // Grants are combinational so a beat is written on the same edge it is offered
  always_comb begin
    gnt = '0;
    if (!rst && !full) begin
      unique case (state)
        IDLE:  if (found && !gap) gnt[win] = 1'b1;
        BURST: if (req[owner]) gnt[owner] = 1'b1;
        default: gnt = '0;
      endcase
    end
  end

  assign wt_en = |gnt;
  assign busy  = (state == BURST);

  always_comb begin
    wdata = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt[i]) wdata = wdata | req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  always_ff @(posedge wt_clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      beat_cnt  <= '0;
      stall_cnt <= '0;
      gap       <= 1'b0;
      ovf_err   <= 1'b0;
      tmo_pulse <= 1'b0;
    end else begin
      tmo_pulse <= 1'b0;
      gap       <= 1'b0;
      if (overflow && wt_en) ovf_err <= 1'b1;
      unique case (state)
        IDLE: begin
          if (!gap && found && !full) begin
            owner <= win;
            if (req_last[win] || MAX_BURST == 1) begin
              rr_ptr <= nxt(win);
            end else begin
              state     <= BURST;
              beat_cnt  <= BW'(1);
              stall_cnt <= '0;
            end
          end
        end
        BURST: begin
          if (!full && req[owner]) begin
            beat_cnt  <= beat_cnt + BW'(1);
            stall_cnt <= '0;
            if (req_last[owner] || beat_cnt == BW'(MAX_BURST - 1)) begin
              state  <= IDLE;
              rr_ptr <= nxt(owner);
              gap    <= 1'b1;
            end
          end else if (!full) begin
            stall_cnt <= stall_cnt + TW'(1);
            if (stall_cnt == TW'(TIMEOUT - 1)) begin
              state     <= IDLE;
              rr_ptr    <= nxt(owner);
              gap       <= 1'b1;
              tmo_pulse <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
